// File: rtl/simt_sched_pkg.sv
// rtl/simt_sched_pkg.sv - shared state encodings and interface constants for simt_scheduler
package simt_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_REQUEST  = 4'd3,
        ST_WAIT     = 4'd4,
        ST_EXECUTE  = 4'd5,
        ST_UPDATE   = 4'd6,
        ST_DONE     = 4'd7,
        ST_SCHEDULE = 4'd8
    } core_state_t;

    localparam logic [2:0] FETCHER_FETCHED = 3'b010;
    localparam logic [1:0] LSU_REQUESTING  = 2'b01;
    localparam logic [1:0] LSU_WAITING     = 2'b10;

endpackage

// File: rtl/pc_min_select.sv
// rtl/pc_min_select.sv - unsigned minimum PC over live threads and the mask of threads at it
module pc_min_select #(
    parameter int THREADS  = 4,
    parameter int PC_WIDTH = 8
) (
    input  logic [THREADS-1:0][PC_WIDTH-1:0] i_thread_pc,
    input  logic [THREADS-1:0]               i_live,
    output logic [PC_WIDTH-1:0]              o_min_pc,
    output logic [THREADS-1:0]               o_match_mask,
    output logic                             o_any_live
);

    logic [PC_WIDTH-1:0] w_min;
    logic                w_any;
    logic [THREADS-1:0]  w_mask;

    always_comb begin
        w_min  = '0;
        w_any  = 1'b0;
        w_mask = '0;
        for (int i = 0; i < THREADS; i++) begin
            if (i_live[i] && (!w_any || i_thread_pc[i] < w_min)) begin
                w_min = i_thread_pc[i];
                w_any = 1'b1;
            end
        end
        // Equal PCs always merge, which is what reconverges diverged threads.
        for (int i = 0; i < THREADS; i++) begin
            w_mask[i] = i_live[i] && (i_thread_pc[i] == w_min);
        end
    end

    assign o_min_pc     = w_min;
    assign o_match_mask = w_mask;
    assign o_any_live   = w_any;

endmodule

// File: rtl/simt_scheduler.sv
// rtl/simt_scheduler.sv - per-core scheduler with per-thread PCs, divergence and reconvergence
module simt_scheduler
    import simt_sched_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic                                      decoded_mem_read_enable,
    input  logic                                      decoded_mem_write_enable,
    input  logic                                      decoded_ret,
    input  logic [2:0]                                fetcher_state,
    input  logic [THREADS_PER_BLOCK-1:0][1:0]         lsu_state,
    input  logic [THREADS_PER_BLOCK-1:0][PC_WIDTH-1:0] next_pc,
    input  logic [$clog2(THREADS_PER_BLOCK):0]        thread_count,
    output logic [PC_WIDTH-1:0]                       current_pc,
    output logic [THREADS_PER_BLOCK-1:0]              active_mask,
    output logic [3:0]                                core_state,
    output logic                                      done,
    output logic [CNT_WIDTH-1:0]                      instr_issued,
    output logic [CNT_WIDTH-1:0]                      diverged_issues,
    output logic [CNT_WIDTH-1:0]                      total_cycles
);

    localparam int T = THREADS_PER_BLOCK;

    core_state_t                 r_state, w_next_state;
    logic [T-1:0][PC_WIDTH-1:0]  r_thread_pc;
    logic [T-1:0]                r_live;
    logic [PC_WIDTH-1:0]         r_current_pc;
    logic [T-1:0]                r_active_mask;
    logic                        r_done;
    logic [CNT_WIDTH-1:0]        r_instr_issued, r_diverged_issues, r_total_cycles;

    logic [PC_WIDTH-1:0]         w_min_pc;
    logic [T-1:0]                w_match_mask;
    logic                        w_any_live;
    logic [31:0]                 w_tc_clamped;
    logic [T-1:0]                w_init_live;
    logic                        w_lsu_busy;
    logic                        w_unused_decoded;

    assign w_unused_decoded = decoded_mem_read_enable ^ decoded_mem_write_enable;

    pc_min_select #(
        .THREADS  (T),
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_min_select (
        .i_thread_pc  (r_thread_pc),
        .i_live       (r_live),
        .o_min_pc     (w_min_pc),
        .o_match_mask (w_match_mask),
        .o_any_live   (w_any_live)
    );

    assign w_tc_clamped = (32'(thread_count) > 32'(T)) ? 32'(T) : 32'(thread_count);

    always_comb begin
        w_init_live = '0;
        w_lsu_busy  = 1'b0;
        for (int i = 0; i < T; i++) begin
            w_init_live[i] = (32'(i) < w_tc_clamped);
            // Only threads executing this instruction may hold the core in WAIT.
            if (r_active_mask[i] &&
                (lsu_state[i] == LSU_REQUESTING || lsu_state[i] == LSU_WAITING)) begin
                w_lsu_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (start) w_next_state = ST_SCHEDULE;
            ST_SCHEDULE: w_next_state = w_any_live ? ST_FETCH : ST_DONE;
            ST_FETCH:    if (fetcher_state == FETCHER_FETCHED) w_next_state = ST_DECODE;
            ST_DECODE:   w_next_state = ST_REQUEST;
            ST_REQUEST:  w_next_state = ST_WAIT;
            ST_WAIT:     if (!w_lsu_busy) w_next_state = ST_EXECUTE;
            ST_EXECUTE:  w_next_state = ST_UPDATE;
            ST_UPDATE:   w_next_state = ST_SCHEDULE;
            ST_DONE:     w_next_state = ST_DONE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_thread_pc       <= '0;
            r_live            <= '0;
            r_current_pc      <= '0;
            r_active_mask     <= '0;
            r_done            <= 1'b0;
            r_instr_issued    <= '0;
            r_diverged_issues <= '0;
            r_total_cycles    <= '0;
        end else begin
            if (r_state != ST_IDLE && r_state != ST_DONE) begin
                r_total_cycles <= r_total_cycles + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_thread_pc <= '0;
                        r_live      <= w_init_live;
                    end
                end
                ST_SCHEDULE: begin
                    r_current_pc  <= w_min_pc;
                    r_active_mask <= w_match_mask;
                    if (!w_any_live) begin
                        r_done <= 1'b1;
                    end else begin
                        r_instr_issued <= r_instr_issued + 1'b1;
                        if (w_match_mask != r_live) begin
                            r_diverged_issues <= r_diverged_issues + 1'b1;
                        end
                    end
                end
                ST_UPDATE: begin
                    for (int i = 0; i < T; i++) begin
                        if (r_active_mask[i]) begin
                            if (decoded_ret) begin
                                r_live[i] <= 1'b0;
                            end else begin
                                r_thread_pc[i] <= next_pc[i];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign current_pc      = r_current_pc;
    assign active_mask     = r_active_mask;
    assign core_state      = r_state;
    assign done            = r_done;
    assign instr_issued    = r_instr_issued;
    assign diverged_issues = r_diverged_issues;
    assign total_cycles    = r_total_cycles;

endmodule

// File: tb/tb_simt_scheduler.sv
// tb/tb_simt_scheduler.sv - directed self-checking bench for simt_scheduler with a program-level model
module tb_simt_scheduler;
    import simt_sched_pkg::*;

    localparam int T  = 4;
    localparam int PW = 8;
    localparam int CW = 32;

    logic                 clk = 1'b0;
    logic                 reset, start, rd_en, wr_en, decoded_ret;
    logic [2:0]           fetcher_state;
    logic [T-1:0][1:0]    lsu_state;
    logic [T-1:0][PW-1:0] next_pc;
    logic [2:0]           thread_count;
    logic [PW-1:0]        current_pc;
    logic [T-1:0]         active_mask;
    logic [3:0]           core_state;
    logic                 done;
    logic [CW-1:0]        instr_issued, diverged_issues, total_cycles;

    simt_scheduler #(.THREADS_PER_BLOCK(T), .PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
        .decoded_ret(decoded_ret), .fetcher_state(fetcher_state), .lsu_state(lsu_state),
        .next_pc(next_pc), .thread_count(thread_count), .current_pc(current_pc),
        .active_mask(active_mask), .core_state(core_state), .done(done),
        .instr_issued(instr_issued), .diverged_issues(diverged_issues),
        .total_cycles(total_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Program-level model: thread PCs, liveness, the current issue and counters.
    core_state_t    m_state;
    logic [PW-1:0]  m_pc [T];
    logic [T-1:0]   m_live;
    logic [PW-1:0]  m_cur_pc;
    logic [T-1:0]   m_mask;
    logic           m_done;
    int unsigned    m_issued, m_div, m_cycles;
    int             log_pc[$];
    int             log_mask[$];
    int             test_id = 0;

    function automatic logic [PW-1:0] prog_next(input int tid, input logic [PW-1:0] pc);
        if (test_id == 2 && pc == 1) return (tid < 2) ? PW'(5) : PW'(2);
        if (test_id == 3 && pc == 0) return (tid < 2) ? PW'(1) : PW'(4);
        if (test_id == 3 && pc == 1) return PW'(4);
        if (test_id == 4 && pc == 0) return (tid < 2) ? PW'(7) : PW'(9);
        return pc + 1'b1;
    endfunction

    function automatic logic prog_ret(input logic [PW-1:0] pc);
        case (test_id)
            1:       return pc == 3;
            2:       return pc == 6;
            3:       return pc == 4;
            4:       return pc == 7 || pc == 9;
            default: return pc == 2;
        endcase
    endfunction

    task automatic model_reset();
        m_state = ST_IDLE;
        for (int i = 0; i < T; i++) m_pc[i] = '0;
        m_live = '0; m_cur_pc = '0; m_mask = '0; m_done = 1'b0;
        m_issued = 0; m_div = 0; m_cycles = 0;
    endtask

    task automatic model_step();
        int  tc;
        bool_found: begin end
        if (m_state != ST_IDLE && m_state != ST_DONE) m_cycles++;
        case (m_state)
            ST_IDLE: if (start) begin
                tc = (int'(thread_count) > T) ? T : int'(thread_count);
                for (int i = 0; i < T; i++) begin
                    m_pc[i] = '0;
                    m_live[i] = (i < tc);
                end
                m_state = ST_SCHEDULE;
            end
            ST_SCHEDULE: begin
                logic found;
                found = 1'b0;
                m_mask = '0;
                // Smallest PC value held by any live thread.
                for (int p = 0; p < (1 << PW) && !found; p++) begin
                    for (int i = 0; i < T; i++) begin
                        if (m_live[i] && int'(m_pc[i]) == p) begin
                            found = 1'b1;
                            m_mask[i] = 1'b1;
                            m_cur_pc = PW'(p);
                        end
                    end
                end
                if (!found) begin
                    m_done  = 1'b1;
                    m_state = ST_DONE;
                end else begin
                    m_issued++;
                    if (m_mask != m_live) m_div++;
                    log_pc.push_back(int'(m_cur_pc));
                    log_mask.push_back(int'(m_mask));
                    m_state = ST_FETCH;
                end
            end
            ST_FETCH:   if (fetcher_state == 3'b010) m_state = ST_DECODE;
            ST_DECODE:  m_state = ST_REQUEST;
            ST_REQUEST: m_state = ST_WAIT;
            ST_WAIT: begin
                logic busy;
                busy = 1'b0;
                for (int i = 0; i < T; i++)
                    if (m_mask[i] && (lsu_state[i] == 2'b01 || lsu_state[i] == 2'b10)) busy = 1'b1;
                if (!busy) m_state = ST_EXECUTE;
            end
            ST_EXECUTE: m_state = ST_UPDATE;
            ST_UPDATE: begin
                for (int i = 0; i < T; i++) begin
                    if (m_mask[i]) begin
                        if (decoded_ret) m_live[i] = 1'b0;
                        else m_pc[i] = next_pc[i];
                    end
                end
                m_state = ST_SCHEDULE;
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (reset) begin
            model_reset();
        end else begin
            check("core_state", 64'(core_state), 64'(m_state));
            if (m_state != ST_DONE) check("current_pc", 64'(current_pc), 64'(m_cur_pc));
            check("active_mask", 64'(active_mask), 64'(m_mask));
            check("done", 64'(done), 64'(m_done));
            check("instr_issued", 64'(instr_issued), 64'(m_issued));
            check("diverged_issues", 64'(diverged_issues), 64'(m_div));
            check("total_cycles", 64'(total_cycles), 64'(m_cycles));
            model_step();
        end
    end

    int fetch_n = 0;
    int wait_n  = 0;
    int wait_pc1 = 0;

    task automatic drive();
        if (core_state == 4'(ST_FETCH)) fetch_n++; else fetch_n = 0;
        if (core_state == 4'(ST_WAIT)) begin
            wait_n++;
        end else begin
            if (wait_n != 0 && test_id == 3 && m_cur_pc == 1) wait_pc1 = wait_n;
            wait_n = 0;
        end
        fetcher_state = (test_id == 2 && fetch_n < 2) ? 3'b000 : 3'b010;
        lsu_state = '0;
        if (test_id == 3 && m_cur_pc == 1) begin
            lsu_state[3] = 2'b10;
            if (core_state == 4'(ST_WAIT) && wait_n <= 5) lsu_state[0] = 2'b01;
        end
        for (int i = 0; i < T; i++) next_pc[i] = prog_next(i, m_cur_pc);
        decoded_ret = prog_ret(m_cur_pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_start(input logic [2:0] tc);
        log_pc.delete();
        log_mask.delete();
        thread_count = tc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_log(input string name, input int pcs[], input int masks[]);
        check({name, "_issue_count"}, 64'(log_pc.size()), 64'(pcs.size()));
        for (int k = 0; k < pcs.size() && k < log_pc.size(); k++) begin
            check({name, "_issue_pc"}, 64'(log_pc[k]), 64'(pcs[k]));
            check({name, "_issue_mask"}, 64'(log_mask[k]), 64'(masks[k]));
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; rd_en = 1'b0; wr_en = 1'b0; decoded_ret = 1'b0;
        fetcher_state = 3'b010; lsu_state = '0; next_pc = '0; thread_count = 3'd4;
        model_reset();
        tick(); tick();
        check("reset_state", 64'(core_state), 64'd0);
        check("reset_outputs", 64'({current_pc, active_mask, done}), 64'd0);
        reset = 1'b0;
        tick();

        test_id = 1;
        do_start(3'd4);
        run_to_done(300);
        check("t1_issued", 64'(instr_issued), 64'd4);
        check("t1_diverged", 64'(diverged_issues), 64'd0);
        check("t1_cycles", 64'(total_cycles), 64'd29);
        check_log("t1", '{0, 1, 2, 3}, '{15, 15, 15, 15});
        pulse_reset();

        test_id = 2;
        do_start(3'd4);
        run_to_done(400);
        check("t2_diverged", 64'(diverged_issues), 64'd3);
        check_log("t2", '{0, 1, 2, 3, 4, 5, 6}, '{15, 15, 12, 12, 12, 15, 15});
        pulse_reset();

        test_id = 3;
        do_start(3'd4);
        run_to_done(300);
        check("t3_wait_len", 64'(wait_pc1), 64'd6);
        check("t3_diverged", 64'(diverged_issues), 64'd1);
        check_log("t3", '{0, 1, 4}, '{15, 3, 15});
        pulse_reset();

        test_id = 4;
        do_start(3'd4);
        run_to_done(300);
        check("t4_issued", 64'(instr_issued), 64'd3);
        check("t4_diverged", 64'(diverged_issues), 64'd1);
        check_log("t4", '{0, 7, 9}, '{15, 3, 12});
        pulse_reset();

        test_id = 5;
        do_start(3'd0);
        tick();
        check("t5_zero_done", 64'(done), 64'd1);
        check("t5_zero_issued", 64'(instr_issued), 64'd0);
        pulse_reset();

        do_start(3'd7);
        n = 0;
        while (core_state != 4'(ST_WAIT) && n < 20) begin
            tick();
            n++;
        end
        check("t5_reached_wait", 64'(core_state), 64'(ST_WAIT));
        check("t5_clamp_mask", 64'(active_mask), 64'hF);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_state", 64'(core_state), 64'd0);
        check("t5_async_outs", 64'({current_pc, active_mask, done}), 64'd0);
        check("t5_async_cnts", 64'({instr_issued, total_cycles}) | 64'(diverged_issues), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        do_start(3'd4);
        run_to_done(300);
        check_log("t5_rerun", '{0, 1, 2}, '{15, 15, 15});
        check("t5_rerun_issued", 64'(instr_issued), 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
